exe_stage_mc: RTL

//  Next-generation execute stage: forwarding muxes, single-cycle ALU, iterative multiplier, registered EXE/MEM output.

---
 rtl/exe_stage_mc_if.sv | 38 +++
 rtl/exe_stage_mc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/exe_stage_mc_if.sv
// Execute-stage bundle: issue request, forwarding sources and registered result.
// Ports: the master modport drives the issue side (ID/EXE) and observes the result.
//        The slave modport is the execute stage: it takes the issue and returns ready and the result.
interface exe_stage_mc_if #(
  parameter int WIDTH       = 32,
  parameter int CMD_LEN     = 4,
  parameter int FWD_SEL_LEN = 2,
  parameter int DEST_LEN    = 5
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [CMD_LEN-1:0]     EXE_CMD;
  logic [FWD_SEL_LEN-1:0] val1_sel;
  logic [FWD_SEL_LEN-1:0] val2_sel;
  logic [FWD_SEL_LEN-1:0] ST_val_sel;
  logic [WIDTH-1:0]       val1;
  logic [WIDTH-1:0]       val2;
  logic [WIDTH-1:0]       ALU_res_MEM;
  logic [WIDTH-1:0]       result_WB;
  logic [WIDTH-1:0]       ST_value_in;
  logic [DEST_LEN-1:0]    dest_in;
  logic                   out_valid;
  logic [WIDTH-1:0]       ALUResult;
  logic [WIDTH-1:0]       ST_value_out;
  logic [DEST_LEN-1:0]    dest_out;

  modport master (
    output in_valid, EXE_CMD, val1_sel, val2_sel, ST_val_sel,
           val1, val2, ALU_res_MEM, result_WB, ST_value_in, dest_in,
    input  in_ready, out_valid, ALUResult, ST_value_out, dest_out
  );

  modport slave (
    input  in_valid, EXE_CMD, val1_sel, val2_sel, ST_val_sel,
           val1, val2, ALU_res_MEM, result_WB, ST_value_in, dest_in,
    output in_ready, out_valid, ALUResult, ST_value_out, dest_out
  );
endinterface

// File: rtl/exe_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, radix-2 shift-add multiplier, registered EXE/MEM output.
// Latency: 1 cycle for ALU ops, WIDTH cycles for MUL (result in the WIDTH-th cycle after acceptance).
// Backpressure: in_ready drops while a multiply runs; no downstream backpressure (MEM always consumes out_valid).
// Ports: clk, rst (synchronous, active-high); bus = exe_stage_mc_if.slave carrying the issue
//        request, forwarding sources, in_ready and the registered result.
module exe_stage_mc #(
  parameter int WIDTH       = 32,
  parameter int CMD_LEN     = 4,
  parameter int FWD_SEL_LEN = 2,
  parameter int DEST_LEN    = 5
) (
  input  logic           clk,
  input  logic           rst,
  exe_stage_mc_if.slave  bus
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [CMD_LEN-1:0] CMD_ADD = CMD_LEN'(4'b0000);
  localparam logic [CMD_LEN-1:0] CMD_SUB = CMD_LEN'(4'b0010);
  localparam logic [CMD_LEN-1:0] CMD_AND = CMD_LEN'(4'b0100);
  localparam logic [CMD_LEN-1:0] CMD_OR  = CMD_LEN'(4'b0101);
  localparam logic [CMD_LEN-1:0] CMD_NOR = CMD_LEN'(4'b0110);
  localparam logic [CMD_LEN-1:0] CMD_XOR = CMD_LEN'(4'b0111);
  localparam logic [CMD_LEN-1:0] CMD_SLL = CMD_LEN'(4'b1000);
  localparam logic [CMD_LEN-1:0] CMD_SRA = CMD_LEN'(4'b1001);
  localparam logic [CMD_LEN-1:0] CMD_SRL = CMD_LEN'(4'b1010);
  localparam logic [CMD_LEN-1:0] CMD_MUL = CMD_LEN'(4'b1100);

  // The accept edge performs the first multiply step, so the MUL state covers
  // the remaining WIDTH-1 steps; the counter's last value finishes the op.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              state_q, state_d;
  logic                mul_done;

  logic [WIDTH-1:0]    op1, op2, st_sel;
  logic [SH_W-1:0]     sh;
  logic [WIDTH-1:0]    alu_res;
  logic                accept;
  logic                is_mul;

  logic [WIDTH-1:0]    acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0]    addend;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    st_hold_q;
  logic [DEST_LEN-1:0] dest_hold_q;

  logic                out_valid_q;
  logic [WIDTH-1:0]    result_q;
  logic [WIDTH-1:0]    st_out_q;
  logic [DEST_LEN-1:0] dest_out_q;

  // Select 0 and 3 both take the register-file value.
  function automatic logic [WIDTH-1:0] fwd(input logic [FWD_SEL_LEN-1:0] sel,
                                           input logic [WIDTH-1:0] reg_v,
                                           input logic [WIDTH-1:0] mem_v,
                                           input logic [WIDTH-1:0] wb_v);
    logic [WIDTH-1:0] r;
    r = reg_v;
    if (sel == FWD_SEL_LEN'(1))      r = mem_v;
    else if (sel == FWD_SEL_LEN'(2)) r = wb_v;
    return r;
  endfunction

  assign op1    = fwd(bus.val1_sel,   bus.val1,        bus.ALU_res_MEM, bus.result_WB);
  assign op2    = fwd(bus.val2_sel,   bus.val2,        bus.ALU_res_MEM, bus.result_WB);
  assign st_sel = fwd(bus.ST_val_sel, bus.ST_value_in, bus.ALU_res_MEM, bus.result_WB);
  assign sh     = op2[SH_W-1:0];

  assign bus.in_ready = (state_q == S_IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_mul       = (bus.EXE_CMD == CMD_MUL);

  always_comb begin
    alu_res = '0;
    case (bus.EXE_CMD)
      CMD_ADD: alu_res = op1 + op2;
      CMD_SUB: alu_res = op1 - op2;
      CMD_AND: alu_res = op1 & op2;
      CMD_OR:  alu_res = op1 | op2;
      CMD_NOR: alu_res = ~(op1 | op2);
      CMD_XOR: alu_res = op1 ^ op2;
      CMD_SLL: alu_res = op1 << sh;
      CMD_SRA: alu_res = $signed(op1) >>> sh;
      CMD_SRL: alu_res = op1 >> sh;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE: if (accept && is_mul) state_d = S_MUL;
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = S_IDLE;
          mul_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign addend = mplier_q[0] ? mcand_q : '0;

  // Operands live only in acc/mcand/mplier once accepted, so forwarding
  // inputs changing during the multiply cannot disturb the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      st_out_q    <= '0;
      dest_out_q  <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      st_hold_q   <= '0;
      dest_hold_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          acc_q       <= op2[0] ? op1 : '0;
          mcand_q     <= op1 << 1;
          mplier_q    <= op2 >> 1;
          cnt_q       <= '0;
          st_hold_q   <= st_sel;
          dest_hold_q <= bus.dest_in;
        end else begin
          out_valid_q <= 1'b1;
          result_q    <= alu_res;
          st_out_q    <= st_sel;
          dest_out_q  <= bus.dest_in;
        end
      end else if (state_q == S_MUL) begin
        if (mul_done) begin
          out_valid_q <= 1'b1;
          result_q    <= acc_q + addend;
          st_out_q    <= st_hold_q;
          dest_out_q  <= dest_hold_q;
        end else begin
          acc_q    <= acc_q + addend;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.ALUResult    = result_q;
  assign bus.ST_value_out = st_out_q;
  assign bus.dest_out     = dest_out_q;

endmodule
